// File: rtl/counter_pkg.sv
// Shared definitions for the counter library.
//   mode_e : output-code / counting mode select (binary, Gray, saturate, hold)
//   clog2  : bits needed to index 'value' states, used for parameter checks
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_SAT  = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned    bits;
        longint unsigned span;
        bits = 0;
        span = 1;
        while (span < longint'(value)) begin
            span = span << 1;
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-reflected-Gray converter.
//   bin  : binary input, WIDTH bits
//   gray : Gray-coded output, WIDTH bits
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/counter_multimode.sv
// WIDTH-bit modulo counter with up/down, synchronous load and a selectable
// registered output code.
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   enable     : advance the index on this edge
//   up         : 1 = increment, 0 = decrement
//   load       : synchronous load of load_value (clamped to MODULUS-1), beats enable
//   load_value : value to load
//   mode       : 0 binary wrap, 1 Gray wrap, 2 binary saturate, 3 hold
//   out        : registered encoded index
//   count      : registered binary index
//   terminal   : index sits at the end point for the current direction
//   wrapped    : one-cycle registered pulse after a wrap step
module counter_multimode
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 2 ** WIDTH,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrapped
);

    localparam int unsigned      MOD_BITS = clog2(MODULUS);
    localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] START    = WIDTH'(RESET_VALUE);

    if (WIDTH < 2) begin : g_bad_width
        $error("counter_multimode: WIDTH must be at least 2");
    end
    if (MODULUS < 2 || MOD_BITS > WIDTH) begin : g_bad_modulus
        $error("counter_multimode: MODULUS must lie in 2..2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
        $error("counter_multimode: RESET_VALUE must be below MODULUS");
    end

    mode_e            mode_sel;
    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] next_index;
    logic [WIDTH-1:0] next_gray;
    logic [WIDTH-1:0] next_out;
    logic             next_wrapped;

    assign mode_sel = mode_e'(mode);
    assign clamped  = (load_value > LAST) ? LAST : load_value;

    always_comb begin
        next_index   = count;
        next_wrapped = 1'b0;
        if (load) begin
            next_index = clamped;
        end else if (enable && mode_sel != MODE_HOLD) begin
            if (up) begin
                if (count != LAST) begin
                    next_index = count + WIDTH'(1);
                end else if (mode_sel != MODE_SAT) begin
                    next_index   = '0;
                    next_wrapped = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    next_index = count - WIDTH'(1);
                end else if (mode_sel != MODE_SAT) begin
                    next_index   = LAST;
                    next_wrapped = 1'b1;
                end
            end
        end
    end

    // Encode from the next index so out and count change on the same edge;
    // a mode change alone therefore re-encodes out even with enable low.
    bin2gray #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .bin  (next_index),
        .gray (next_gray)
    );

    assign next_out = (mode_sel == MODE_GRAY) ? next_gray : next_index;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= START;
            out     <= START;
            wrapped <= 1'b0;
        end else begin
            count   <= next_index;
            out     <= next_out;
            wrapped <= next_wrapped;
        end
    end

    assign terminal = up ? (count == LAST) : (count == '0);

endmodule

// File: tb/tb_counter_multimode.sv
// Self-checking bench: two counters (MODULUS 10 and 16) share stimulus and
// are compared against an arithmetic reference model every checked cycle.
module tb_counter_multimode;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic [1:0] mode = 2'd0;

    logic [3:0] out10, count10, out16, count16;
    logic       term10, wrap10, term16, wrap16;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    counter_multimode #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut10 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .mode(mode), .out(out10), .count(count10),
        .terminal(term10), .wrapped(wrap10)
    );

    counter_multimode #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut16 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .mode(mode), .out(out16), .count(count16),
        .terminal(term16), .wrapped(wrap16)
    );

    logic [3:0] d_count[2];
    logic [3:0] d_out[2];
    logic       d_term[2];
    logic       d_wrap[2];
    assign d_count[0] = count10;
    assign d_count[1] = count16;
    assign d_out[0]   = out10;
    assign d_out[1]   = out16;
    assign d_term[0]  = term10;
    assign d_term[1]  = term16;
    assign d_wrap[0]  = wrap10;
    assign d_wrap[1]  = wrap16;

    // Reference model: plain integer index per instance.
    int mods[2] = '{10, 16};
    int m_idx[2];
    int m_out[2];
    bit m_wrap[2];

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    function automatic bit m_term(input int d);
        return up ? (m_idx[d] == mods[d] - 1) : (m_idx[d] == 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idx[d]  = 0;
            m_out[d]  = 0;
            m_wrap[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int m;
            int n;
            m = mods[d];
            m_wrap[d] = 1'b0;
            if (load) begin
                m_idx[d] = (int'(load_value) < m) ? int'(load_value) : m - 1;
            end else if (enable && mode != 2'd3) begin
                n = up ? m_idx[d] + 1 : m_idx[d] - 1;
                if (mode == 2'd2) begin
                    if (n >= 0 && n < m) m_idx[d] = n;
                end else begin
                    m_wrap[d] = (n == m) || (n < 0);
                    m_idx[d]  = (n + m) % m;
                end
            end
            m_out[d] = (mode == 2'd1) ? gray_of(m_idx[d]) : m_idx[d];
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_edge();
        #1;
    endtask

    task automatic test_reset();
        #10;
        reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (d_count[d] !== 4'd0 || d_out[d] !== 4'd0 || d_wrap[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_async dut%0d: count=%0d out=%0d wrapped=%b want 0 0 0",
                         d, d_count[d], d_out[d], d_wrap[d]);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (d_count[d] !== 4'd0 || d_out[d] !== 4'd0) begin
                    bad++;
                    $display("FAIL reset_hold dut%0d cyc%0d: count=%0d out=%0d want 0 0",
                             d, i, d_count[d], d_out[d]);
                end
            end
        end
    endtask

    task automatic test_wrap_up();
        mode = 2'd0; up = 1'b1; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (count10 !== 4'((i + 1) % 10) || wrap10 !== (i == 9) || term10 !== ((i + 1) % 10 == 9)) begin
                bad++;
                $display("FAIL wrap_up cyc%0d: count=%0d wrapped=%b terminal=%b want %0d %b %b",
                         i, count10, wrap10, term10, (i + 1) % 10, i == 9, (i + 1) % 10 == 9);
            end
            total++;
            if (count16 !== 4'(m_idx[1]) || wrap16 !== m_wrap[1]) begin
                bad++;
                $display("FAIL wrap_up16 cyc%0d: count=%0d wrapped=%b want %0d %b",
                         i, count16, wrap16, m_idx[1], m_wrap[1]);
            end
        end
    endtask

    task automatic test_gray_down();
        logic [3:0] exp_out[3];
        logic [3:0] prev;
        exp_out = '{4'b1000, 4'b1001, 4'b1011};
        mode = 2'd1; load = 1'b1; load_value = 4'd0; enable = 1'b0;
        tick();
        load = 1'b0; up = 1'b0; enable = 1'b1;
        prev = out16;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count16 !== 4'(15 - i) || out16 !== exp_out[i] || $countones(prev ^ out16) != 1) begin
                bad++;
                $display("FAIL gray_down cyc%0d: count=%0d out=%b prev=%b want %0d %b single-bit",
                         i, count16, out16, prev, 15 - i, exp_out[i]);
            end
            prev = out16;
            total++;
            if (count10 !== 4'(m_idx[0]) || out10 !== 4'(m_out[0])) begin
                bad++;
                $display("FAIL gray_down10 cyc%0d: count=%0d out=%b want %0d %b",
                         i, count10, out10, m_idx[0], 4'(m_out[0]));
            end
        end
    endtask

    task automatic test_saturate();
        bit seen_wrap;
        seen_wrap = 1'b0;
        mode = 2'd2; load = 1'b1; load_value = 4'd8; up = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 4) up = 1'b0;
            tick();
            seen_wrap = seen_wrap | wrap10 | wrap16;
            total++;
            if (count10 !== 4'(m_idx[0]) || count16 !== 4'(m_idx[1])) begin
                bad++;
                $display("FAIL saturate cyc%0d: count10=%0d count16=%0d want %0d %0d",
                         i, count10, count16, m_idx[0], m_idx[1]);
            end
            if (i < 4) begin
                total++;
                if (count10 !== 4'd9) begin
                    bad++;
                    $display("FAIL sat_top cyc%0d: count=%0d want 9", i, count10);
                end
            end
        end
        total++;
        if (count10 !== 4'd0 || seen_wrap !== 1'b0) begin
            bad++;
            $display("FAIL sat_floor: count=%0d wrapped_seen=%b want 0 0", count10, seen_wrap);
        end
    endtask

    task automatic test_load_clamp();
        mode = 2'd0; up = 1'b1; enable = 1'b1; load = 1'b1; load_value = 4'd13;
        tick();
        total++;
        if (count10 !== 4'd9 || count16 !== 4'd13) begin
            bad++;
            $display("FAIL load_clamp: count10=%0d count16=%0d want 9 13", count10, count16);
        end
        load = 1'b0; mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count10 !== 4'd9 || count16 !== 4'd13 || wrap10 !== 1'b0) begin
                bad++;
                $display("FAIL hold_mode cyc%0d: count10=%0d count16=%0d wrapped=%b want 9 13 0",
                         i, count10, count16, wrap10);
            end
        end
    endtask

    task automatic test_mode_change();
        enable = 1'b0; mode = 2'd1;
        tick();
        total++;
        if (out16 !== 4'b1011 || count16 !== 4'd13 || out10 !== 4'(gray_of(9))) begin
            bad++;
            $display("FAIL mode_to_gray: out16=%b count16=%0d out10=%b want 1011 13 %b",
                     out16, count16, out10, 4'(gray_of(9)));
        end
        mode = 2'd0;
        tick();
        total++;
        if (out16 !== 4'd13 || out10 !== 4'd9) begin
            bad++;
            $display("FAIL mode_to_bin: out16=%0d out10=%0d want 13 9", out16, out10);
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'd0; up = 1'b1; enable = 1'b1; load = 1'b1; load_value = 4'd4;
        tick();
        load = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (count10 !== 4'd0 || count16 !== 4'd0 || wrap10 !== 1'b0 || out10 !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: count10=%0d count16=%0d wrapped=%b out=%0d want 0 0 0 0",
                     count10, count16, wrap10, out10);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (count10 !== 4'(i) || count16 !== 4'(i)) begin
                bad++;
                $display("FAIL resume cyc%0d: count10=%0d count16=%0d want %0d", i, count10, count16, i);
            end
        end
        load = 1'b1; load_value = 4'd9;
        tick();
        load = 1'b0;
        tick();
        total++;
        if (wrap10 !== 1'b1 || count10 !== 4'd0) begin
            bad++;
            $display("FAIL pend_wrap: wrapped=%b count=%0d want 1 0", wrap10, count10);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (wrap10 !== 1'b0 || count16 !== 4'd0) begin
            bad++;
            $display("FAIL reset_clears_wrap: wrapped=%b count16=%0d want 0 0", wrap10, count16);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load       = ($urandom_range(0, 7) == 0);
            load_value = 4'($urandom_range(0, 15));
            enable     = ($urandom_range(0, 3) != 0);
            up         = 1'($urandom);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            tick();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (d_count[d] !== 4'(m_idx[d]) || d_out[d] !== 4'(m_out[d]) ||
                    d_wrap[d] !== m_wrap[d] || d_term[d] !== m_term(d)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d: count=%0d out=%0d wrapped=%b terminal=%b want %0d %0d %b %b",
                             d, i, d_count[d], d_out[d], d_wrap[d], d_term[d],
                             m_idx[d], m_out[d], m_wrap[d], m_term(d));
                end
            end
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                total++;
                if (count10 !== 4'd0 || count16 !== 4'd0 || wrap10 !== 1'b0 || wrap16 !== 1'b0) begin
                    bad++;
                    $display("FAIL random_reset cyc%0d: count10=%0d count16=%0d want 0 0", i, count10, count16);
                end
                @(negedge clock);
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wrap_up();
        test_gray_down();
        test_saturate();
        test_load_clamp();
        test_mode_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
